// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared pipeline types for the memory stage
// Holds the access-size and LSU state encodings next to the stage control word.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10
  } lsu_state_e;

  typedef struct packed {
    logic valid;
    logic stall;
    logic flush;
  } stage_ctrl_t;

  // An access is unusable when its offset is not a multiple of its size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = off[0];
      SIZE_WORD: is_misaligned = |off;
      default:   is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable, store replication and load extract/extend
// Purely combinational lane steering for a 32-bit data bus.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shift;
  mem_size_e   w_size;

  assign w_size  = mem_size_e'(i_size);
  assign w_shift = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    o_be        = 4'b0000;
    o_wdata     = i_wdata;
    o_load_data = w_shift;
    case (w_size)
      SIZE_BYTE: begin
        o_be        = 4'b0001 << i_offset;
        o_wdata     = {4{i_wdata[7:0]}};
        o_load_data = i_unsigned ? {24'b0, w_shift[7:0]}
                                 : {{24{w_shift[7]}}, w_shift[7:0]};
      end
      SIZE_HALF: begin
        o_be        = 4'b0011 << {i_offset[1], 1'b0};
        o_wdata     = {2{i_wdata[15:0]}};
        o_load_data = i_unsigned ? {16'b0, w_shift[15:0]}
                                 : {{16{w_shift[15]}}, w_shift[15:0]};
      end
      SIZE_WORD: begin
        o_be = 4'b1111;
      end
      default: begin
        o_be = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding req/gnt/rvalid data-memory initiator
// Drives the bus for memory-stage loads/stores and raises dmem_stall_o until completion.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_valid_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_size_i,
  input  logic              mem_unsigned_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [3:0]        dmem_be_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  input  logic              dmem_err_i,
  output logic              dmem_stall_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              misaligned_o,
  output logic              bus_err_o
);

  lsu_state_e r_state;
  lsu_state_e w_next;
  logic       w_misaligned;
  logic       w_access;
  logic       w_in_wait;

  assign w_misaligned = is_misaligned(mem_size_i, mem_addr_i[1:0]);
  assign w_access     = mem_valid_i && !w_misaligned;
  assign w_in_wait    = (r_state == LSU_WAIT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= LSU_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // gnt outside IDLE/REQ and rvalid outside WAIT fall through to "hold state".
  always_comb begin
    w_next = r_state;
    case (r_state)
      LSU_IDLE: if (w_access) w_next = dmem_gnt_i ? LSU_WAIT : LSU_REQ;
      LSU_REQ:  if (dmem_gnt_i) w_next = LSU_WAIT;
      LSU_WAIT: if (dmem_rvalid_i) w_next = LSU_IDLE;
      default:  w_next = LSU_IDLE;
    endcase
  end

  assign dmem_req_o   = rst_ni && w_access && (r_state == LSU_IDLE || r_state == LSU_REQ);
  assign dmem_stall_o = rst_ni && w_access && !(w_in_wait && dmem_rvalid_i);
  assign misaligned_o = rst_ni && mem_valid_i && w_misaligned;
  assign bus_err_o    = rst_ni && w_in_wait && dmem_rvalid_i && dmem_err_i;
  assign dmem_we_o    = mem_we_i;
  assign dmem_addr_o  = {mem_addr_i[ADDR_W-1:2], 2'b00};

  lsu_align u_align (
    .i_size      (mem_size_i),
    .i_unsigned  (mem_unsigned_i),
    .i_offset    (mem_addr_i[1:0]),
    .i_wdata     (mem_wdata_i),
    .i_rdata     (dmem_rdata_i),
    .o_be        (dmem_be_o),
    .o_wdata     (dmem_wdata_o),
    .o_load_data (load_data_o)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
// Driver pushes model predictions; a negedge monitor pops them on instruction completion.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        mem_valid_i, mem_we_i, mem_unsigned_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic        dmem_req_o, dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i, dmem_err_i;
  logic [31:0] dmem_rdata_i;
  logic        dmem_stall_o;
  logic [31:0] load_data_o;
  logic        misaligned_o, bus_err_o;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .mem_valid_i(mem_valid_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_unsigned_i(mem_unsigned_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .dmem_err_i(dmem_err_i), .dmem_stall_o(dmem_stall_o), .load_data_o(load_data_o),
    .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        abort;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load;
    logic        mis;
    logic        err;
    int          stall;
    int          reqc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stall_cnt = 0;
  int   req_cnt = 0;
  exp_t m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int g, input int r,
                                 input logic err);
    exp_t e;
    int n, off;
    longint unsigned u, span;
    off = int'(addr[1:0]);
    n = 1 << size;
    e.abort = 1'b0;
    e.we = we;
    e.addr = addr & ~32'd3;
    e.mis = (size == 2'd3) || ((off % n) != 0);
    e.be = '0;
    e.wdata = '0;
    for (int i = 0; i < 4; i++) begin
      e.be[i] = (i >= off) && (i < off + n);
      e.wdata[8*i +: 8] = wdata[8*(i % n) +: 8];
    end
    span = 64'd1 << (8 * n);
    u = (longint'(rdata) >> (8 * off)) & (span - 1);
    if (!uns && u[8*n-1]) u = u - span;
    e.load = u[31:0];
    e.err = !e.mis && err;
    e.stall = e.mis ? 0 : g + r + 1;
    e.reqc = e.mis ? 0 : g + 1;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_ni) begin
      chk("rst_req", dmem_req_o, 0);
      chk("rst_stall", dmem_stall_o, 0);
      chk("rst_mis", misaligned_o, 0);
      chk("rst_buserr", bus_err_o, 0);
      stall_cnt = 0;
      req_cnt = 0;
      if (q.size() > 0 && q[0].abort) void'(q.pop_front());
    end else if (mem_valid_i) begin
      if (dmem_req_o) begin
        if (req_cnt == 0) begin
          if (q.size() == 0) chk("req_unexpected", 1, 0);
          else begin
            chk("req_we", dmem_we_o, q[0].we);
            chk("req_addr", dmem_addr_o, q[0].addr);
            chk("req_be", dmem_be_o, q[0].be);
            if (q[0].we) chk("req_wdata", dmem_wdata_o, q[0].wdata);
          end
        end
        req_cnt++;
      end
      if (dmem_stall_o) stall_cnt++;
      else begin
        if (q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          m = q.pop_front();
          chk("misaligned", misaligned_o, m.mis);
          chk("bus_err", bus_err_o, m.err);
          chk("stall_cycles", stall_cnt, m.stall);
          chk("req_cycles", req_cnt, m.reqc);
          if (!m.we && !m.mis) chk("load_data", load_data_o, m.load);
        end
        stall_cnt = 0;
        req_cnt = 0;
      end
    end else begin
      chk("idle_req", dmem_req_o, 0);
      chk("idle_stall", dmem_stall_o, 0);
      chk("idle_buserr", bus_err_o, 0);
      if (stall_cnt != 0 || req_cnt != 0) begin
        chk("incomplete_access", 1, 0);
        if (q.size() > 0) void'(q.pop_front());
        stall_cnt = 0;
        req_cnt = 0;
      end
    end
  end

  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int g, input int r,
                         input logic err, input int gap);
    exp_t e;
    int n;
    logic rv;
    e = model(we, size, uns, addr, wdata, rdata, g, r, err);
    n = e.mis ? 1 : g + r + 2;
    @(posedge clk); #1;
    q.push_back(e);
    mem_valid_i = 1'b1; mem_we_i = we; mem_size_i = size; mem_unsigned_i = uns;
    mem_addr_i = addr; mem_wdata_i = wdata;
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      rv = (c == g + r + 1);
      dmem_gnt_i = (c == g) || (c > g && $urandom_range(3) == 0);
      dmem_rvalid_i = rv || (c <= g && $urandom_range(3) == 0);
      dmem_rdata_i = rv ? rdata : $urandom;
      dmem_err_i = rv ? err : 1'($urandom_range(1));
    end
    for (int k = 0; k < gap; k++) begin
      @(posedge clk); #1;
      mem_valid_i = 1'b0;
      dmem_gnt_i = 1'($urandom_range(1));
      dmem_rvalid_i = 1'($urandom_range(1));
      dmem_err_i = 1'($urandom_range(1));
      dmem_rdata_i = $urandom;
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    mem_valid_i = 0; mem_we_i = 0; mem_size_i = 0; mem_unsigned_i = 0;
    mem_addr_i = 0; mem_wdata_i = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0; dmem_err_i = 0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    run_txn(0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 1);
    run_txn(0, 2'd0, 0, 32'h103, 32'h0, 32'h80000000, 0, 0, 0, 1);
    run_txn(0, 2'd0, 1, 32'h103, 32'h0, 32'h80000000, 0, 0, 0, 0);
    run_txn(1, 2'd1, 0, 32'h202, 32'h1234, 32'h0, 3, 0, 0, 1);
    run_txn(0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 0, 0, 0, 1);
    run_txn(0, 2'd3, 0, 32'h100, 32'h0, 32'h0, 0, 0, 0, 1);
    run_txn(0, 2'd2, 0, 32'h400, 32'h0, 32'h55AA55AA, 1, 2, 1, 2);

    // reset pulse while WAIT, then a stray rvalid in IDLE
    @(posedge clk); #1;
    m = model(0, 2'd2, 0, 32'h300, 32'h0, 32'h0, 0, 0, 0);
    m.abort = 1'b1;
    q.push_back(m);
    mem_valid_i = 1; mem_we_i = 0; mem_size_i = 2'd2; mem_addr_i = 32'h300;
    dmem_gnt_i = 1; dmem_rvalid_i = 0;
    @(posedge clk); #1;
    dmem_gnt_i = 0;
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_async_req", dmem_req_o, 0);
    chk("rst_async_stall", dmem_stall_o, 0);
    @(posedge clk); #1;
    mem_valid_i = 0; rst_ni = 1'b1;
    dmem_rvalid_i = 1; dmem_err_i = 1;
    @(posedge clk); #1;
    dmem_rvalid_i = 0; dmem_err_i = 0;
    run_txn(0, 2'd1, 0, 32'h502, 32'h0, 32'hBEEF0000, 1, 1, 0, 1);

    for (int t = 0; t < 300; t++) begin
      logic [1:0] sz;
      logic [31:0] a;
      sz = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
      a = $urandom;
      if ($urandom_range(3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      run_txn(1'($urandom_range(1)), sz, 1'($urandom_range(1)), a, $urandom, $urandom,
              $urandom_range(3), $urandom_range(3), ($urandom_range(4) == 0),
              $urandom_range(1));
    end

    @(posedge clk); #1;
    mem_valid_i = 0; dmem_gnt_i = 0; dmem_rvalid_i = 0;
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
